// File: rtl/regfile_wq_pkg.sv
// Shared constants and types for the register-bank write queue.
// Optional feature macro: REGFILE_WRITE_QUEUE_BYPASS_EN (youngest-match forwarding data).
package regfile_wq_pkg;

    localparam int unsigned NB_BITS         = 32;
    localparam int unsigned NB_BITS_ADDRESS = 5;
    localparam int unsigned FIFO_DEPTH      = 4;

    // Queue entry layout at the default widths. Modules parameterised away from the
    // defaults declare a local copy with the same field names and order.
    typedef struct packed {
        logic [NB_BITS_ADDRESS-1:0] add;
        logic [NB_BITS-1:0]         data;
    } wq_entry_t;

    // Pointer width for a power-of-two depth; pointers wrap by natural overflow.
    function automatic int unsigned wq_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wq_match_unit.sv
// Scans the occupied queue entries for one decode-stage source register.
// Produces the pending bit and, with REGFILE_WRITE_QUEUE_BYPASS_EN defined, the data of
// the youngest matching entry.
module wq_match_unit
    import regfile_wq_pkg::*;
#(
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    parameter int unsigned nb_bits         = NB_BITS,
`endif
    parameter int unsigned nb_bits_address = NB_BITS_ADDRESS,
    parameter int unsigned fifo_depth      = FIFO_DEPTH
) (
    input  logic [nb_bits_address-1:0]    rs_add_i,
    input  logic [wq_ptr_w(fifo_depth)-1:0] rd_ptr_i,
    input  logic [wq_ptr_w(fifo_depth):0]   count_i,
    input  logic [nb_bits_address-1:0]    ent_add_i [fifo_depth],
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    input  logic [nb_bits-1:0]            ent_data_i [fifo_depth],
    output logic [nb_bits-1:0]            fwd_data_o,
`endif
    output logic                          pending_o
);

    localparam int unsigned PtrW = wq_ptr_w(fifo_depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] idx;

    // Walk entries oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        pending_o = 1'b0;
        idx       = '0;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        fwd_data_o = '0;
`endif
        for (int unsigned k = 0; k < fifo_depth; k++) begin
            idx = rd_ptr_i + PtrW'(k);
            if ((CntW'(k) < count_i) && (rs_add_i != '0) && (ent_add_i[idx] == rs_add_i)) begin
                pending_o = 1'b1;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
                fwd_data_o = ent_data_i[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Writer-side front end of the integer register bank: buffers writeback requests in a
// small FIFO, drains one entry per cycle into the bank write port and flags source
// registers that still have an uncommitted write queued.
// Optional feature macro: REGFILE_WRITE_QUEUE_BYPASS_EN adds rs1/rs2 forwarding data.
module regfile_write_queue
    import regfile_wq_pkg::*;
#(
    parameter int unsigned nb_bits         = NB_BITS,
    parameter int unsigned nb_bits_address = NB_BITS_ADDRESS,
    parameter int unsigned fifo_depth      = FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [nb_bits_address-1:0] wb_add_i,
    input  logic [nb_bits-1:0]         wb_data_i,
    input  logic                       hold_i,
    output logic                       write_enable_o,
    output logic [nb_bits_address-1:0] rd_add_o,
    output logic [nb_bits-1:0]         rd_data_o,
    input  logic [nb_bits_address-1:0] rs1_add_i,
    input  logic [nb_bits_address-1:0] rs2_add_i,
    output logic                       rs1_pending_o,
    output logic                       rs2_pending_o,
    output logic                       empty_o,
    output logic                       full_o
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    ,
    output logic [nb_bits-1:0]         rs1_fwd_data_o,
    output logic [nb_bits-1:0]         rs2_fwd_data_o
`endif
);

    localparam int unsigned PtrW = wq_ptr_w(fifo_depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [nb_bits_address-1:0] add;
        logic [nb_bits-1:0]         data;
    } entry_t;

    entry_t          mem_q [fifo_depth];
    entry_t          mem_d [fifo_depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic empty;
    logic full;

    logic [nb_bits_address-1:0] ent_add [fifo_depth];
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    logic [nb_bits-1:0]         ent_data [fifo_depth];
`endif

    // Queue status, handshake and bank write port.
    always_comb begin
        empty          = (count_q == '0);
        full           = (count_q == CntW'(fifo_depth));
        empty_o        = empty;
        full_o         = full;
        wb_ready_o     = !full;
        // Writes to x0 complete the handshake but are never enqueued.
        push           = wb_valid_i && !full && (wb_add_i != '0);
        pop            = !empty && !hold_i;
        write_enable_o = pop;
        rd_add_o       = empty ? '0 : mem_q[rd_ptr_q].add;
        rd_data_o      = empty ? '0 : mem_q[rd_ptr_q].data;
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{add: wb_add_i, data: wb_data_i};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every queued write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(fifo_depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Split storage into flat arrays for the match units.
    always_comb begin
        for (int i = 0; i < int'(fifo_depth); i++) begin
            ent_add[i] = mem_q[i].add;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
            ent_data[i] = mem_q[i].data;
`endif
        end
    end

    wq_match_unit #(
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .nb_bits         (nb_bits),
`endif
        .nb_bits_address (nb_bits_address),
        .fifo_depth      (fifo_depth)
    ) u_match_rs1 (
        .rs_add_i   (rs1_add_i),
        .rd_ptr_i   (rd_ptr_q),
        .count_i    (count_q),
        .ent_add_i  (ent_add),
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .ent_data_i (ent_data),
        .fwd_data_o (rs1_fwd_data_o),
`endif
        .pending_o  (rs1_pending_o)
    );

    wq_match_unit #(
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .nb_bits         (nb_bits),
`endif
        .nb_bits_address (nb_bits_address),
        .fifo_depth      (fifo_depth)
    ) u_match_rs2 (
        .rs_add_i   (rs2_add_i),
        .rd_ptr_i   (rd_ptr_q),
        .count_i    (count_q),
        .ent_add_i  (ent_add),
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        .ent_data_i (ent_data),
        .fwd_data_o (rs2_fwd_data_o),
`endif
        .pending_o  (rs2_pending_o)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
module tb_regfile_write_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [4:0]  wb_add_i;
    logic [31:0] wb_data_i;
    logic        hold_i;
    logic        write_enable_o;
    logic [4:0]  rd_add_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rs1_add_i;
    logic [4:0]  rs2_add_i;
    logic        rs1_pending_o;
    logic        rs2_pending_o;
    logic        empty_o;
    logic        full_o;
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    logic [31:0] rs1_fwd_data_o;
    logic [31:0] rs2_fwd_data_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_queue #(
        .nb_bits         (32),
        .nb_bits_address (5),
        .fifo_depth      (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wb_valid_i     (wb_valid_i),
        .wb_ready_o     (wb_ready_o),
        .wb_add_i       (wb_add_i),
        .wb_data_i      (wb_data_i),
        .hold_i         (hold_i),
        .write_enable_o (write_enable_o),
        .rd_add_o       (rd_add_o),
        .rd_data_o      (rd_data_o),
        .rs1_add_i      (rs1_add_i),
        .rs2_add_i      (rs2_add_i),
        .rs1_pending_o  (rs1_pending_o),
        .rs2_pending_o  (rs2_pending_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        ,
        .rs1_fwd_data_o (rs1_fwd_data_o),
        .rs2_fwd_data_o (rs2_fwd_data_o)
`endif
    );

    // Presents one request for exactly one edge, returning 1 unit after that edge.
    task automatic push_one(input logic [4:0] add, input logic [31:0] data);
        wb_valid_i = 1'b1;
        wb_add_i   = add;
        wb_data_i  = data;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #3;
        n_checks++;
        if ({wb_ready_o, empty_o, full_o, write_enable_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/emp/full/we=%b expected 1100",
                     {wb_ready_o, empty_o, full_o, write_enable_o});
        end
        n_checks++;
        if ({rd_add_o, rd_data_o, rs1_pending_o, rs2_pending_o} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_port: got add=%h data=%h p1=%b p2=%b expected all 0",
                     rd_add_o, rd_data_o, rs1_pending_o, rs2_pending_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        hold_i    = 1'b1;
        rs1_add_i = 5'd2;
        push_one(5'd1, 32'hA1);
        push_one(5'd2, 32'hA2);
        push_one(5'd3, 32'hA3);
        n_checks++;
        if (empty_o !== 1'b0 || rs1_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_filled: got empty=%b p1=%b expected 0 1", empty_o, rs1_pending_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({wb_ready_o, empty_o, full_o, rs1_pending_o} !== 4'b1100
            || rd_add_o !== 5'd0 || rd_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy/emp/full/p1=%b add=%h data=%h expected 1100 0 0",
                     {wb_ready_o, empty_o, full_o, rs1_pending_o}, rd_add_o, rd_data_o);
        end
        @(negedge clk);
        rst_i  = 1'b1;
        hold_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (write_enable_o !== 1'b0 || empty_o !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got we=%b empty=%b expected 0 1",
                         i, write_enable_o, empty_o);
            end
        end
    endtask

    task automatic test_single();
        hold_i     = 1'b0;
        wb_valid_i = 1'b1;
        wb_add_i   = 5'd5;
        wb_data_i  = 32'hDEADBEEF;
        n_checks++;
        if (wb_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", wb_ready_o);
        end
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
        n_checks++;
        if (write_enable_o !== 1'b1 || rd_add_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_write: got we=%b add=%0d data=%h expected 1 5 deadbeef",
                     write_enable_o, rd_add_o, rd_data_o);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (write_enable_o !== 1'b0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_once: got we=%b empty=%b expected 0 1", write_enable_o, empty_o);
        end
    endtask

    task automatic test_full();
        hold_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_one(5'(i), 32'h100 + 32'(i));
        end
        n_checks++;
        if (full_o !== 1'b1 || wb_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flags: got full=%b ready=%b expected 1 0", full_o, wb_ready_o);
        end
        rs1_add_i = 5'd9;
        push_one(5'd9, 32'h999);
        n_checks++;
        if (full_o !== 1'b1 || rs1_pending_o !== 1'b0 || write_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_reject: got full=%b p1=%b we=%b expected 1 0 0",
                     full_o, rs1_pending_o, write_enable_o);
        end
        hold_i = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (write_enable_o !== 1'b1 || rd_add_o !== 5'(i) || rd_data_o !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got we=%b add=%0d data=%h expected 1 %0d %h",
                         i, write_enable_o, rd_add_o, rd_data_o, i, 32'h100 + 32'(i));
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (empty_o !== 1'b1 || write_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got empty=%b we=%b expected 1 0", empty_o, write_enable_o);
        end
    endtask

    task automatic test_x0();
        hold_i     = 1'b0;
        rs1_add_i  = 5'd0;
        wb_valid_i = 1'b1;
        wb_add_i   = 5'd0;
        wb_data_i  = 32'h1234;
        n_checks++;
        if (wb_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: got %b expected 1", wb_ready_o);
        end
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
        n_checks++;
        if (empty_o !== 1'b1 || write_enable_o !== 1'b0 || rs1_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_drop: got empty=%b we=%b p1=%b expected 1 0 0",
                     empty_o, write_enable_o, rs1_pending_o);
        end
    endtask

    task automatic test_pending();
        hold_i    = 1'b1;
        rs1_add_i = 5'd3;
        rs2_add_i = 5'd7;
        push_one(5'd7, 32'h11);
        push_one(5'd7, 32'h22);
        n_checks++;
        if (rs2_pending_o !== 1'b1 || rs1_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_set: got p2=%b p1=%b expected 1 0", rs2_pending_o, rs1_pending_o);
        end
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        n_checks++;
        if (rs2_fwd_data_o !== 32'h22 || rs1_fwd_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL pend_fwd: got fwd2=%h fwd1=%h expected 22 0", rs2_fwd_data_o, rs1_fwd_data_o);
        end
`endif
        hold_i = 1'b0;
        #1;
        n_checks++;
        if (write_enable_o !== 1'b1 || rd_data_o !== 32'h11 || rs2_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_first: got we=%b data=%h p2=%b expected 1 11 1",
                     write_enable_o, rd_data_o, rs2_pending_o);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (write_enable_o !== 1'b1 || rd_data_o !== 32'h22 || rs2_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_second: got we=%b data=%h p2=%b expected 1 22 1",
                     write_enable_o, rd_data_o, rs2_pending_o);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (write_enable_o !== 1'b0 || rs2_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_clear: got we=%b p2=%b expected 0 0", write_enable_o, rs2_pending_o);
        end
`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
        n_checks++;
        if (rs2_fwd_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL pend_fwd_clear: got %h expected 0", rs2_fwd_data_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        hold_i = 1'b0;
        push_one(5'd10, 32'hA0);
        for (int i = 0; i < 8; i++) begin
            wb_valid_i = 1'b1;
            wb_add_i   = 5'(11 + i);
            wb_data_i  = 32'hA1 + 32'(i);
            n_checks++;
            if (write_enable_o !== 1'b1 || rd_add_o !== 5'(10 + i) || rd_data_o !== 32'hA0 + 32'(i)
                || empty_o !== 1'b0 || full_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got we=%b add=%0d data=%h emp=%b full=%b expected 1 %0d %h 0 0",
                         i, write_enable_o, rd_add_o, rd_data_o, empty_o, full_o,
                         10 + i, 32'hA0 + 32'(i));
            end
            @(posedge clk);
            #1;
        end
        wb_valid_i = 1'b0;
        n_checks++;
        if (rd_add_o !== 5'd18 || rd_data_o !== 32'hA8 || write_enable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_last: got we=%b add=%0d data=%h expected 1 18 a8",
                     write_enable_o, rd_add_o, rd_data_o);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (empty_o !== 1'b1 || write_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got empty=%b we=%b expected 1 0", empty_o, write_enable_o);
        end
    endtask

    initial begin
        wb_valid_i = 1'b0;
        wb_add_i   = '0;
        wb_data_i  = '0;
        hold_i     = 1'b0;
        rs1_add_i  = '0;
        rs2_add_i  = '0;
        test_reset();
        test_reset_midstream();
        test_single();
        test_full();
        test_x0();
        test_pending();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
